// File: rtl/display_scanner.sv
// N-digit seven-segment scan driver with hex decode, decimal points, per-digit enable,
// blink, leading-zero blanking, per-slot dead time and frame-synchronous content updates.
module display_scanner #(
  parameter int NUM_DIGITS   = 8,
  parameter int SLOT_CYCLES  = 12500,
  parameter int BLANK_CYCLES = 250,
  parameter int BLINK_FRAMES = 250,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   enable_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    lz_suppress,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [3:0]              bcd_out,
  output logic [IW-1:0]           digit_sel,
  output logic                    frame_start
);

  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  // Captured display content: {lz, blink, enable, dp, digits}
  localparam int CW = 7 * NUM_DIGITS + 1;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] code;
    case (value)
      4'h0:    code = 7'h40;
      4'h1:    code = 7'h79;
      4'h2:    code = 7'h24;
      4'h3:    code = 7'h30;
      4'h4:    code = 7'h19;
      4'h5:    code = 7'h12;
      4'h6:    code = 7'h02;
      4'h7:    code = 7'h78;
      4'h8:    code = 7'h00;
      4'h9:    code = 7'h10;
      4'hA:    code = 7'h08;
      4'hB:    code = 7'h03;
      4'hC:    code = 7'h46;
      4'hD:    code = 7'h21;
      4'hE:    code = 7'h06;
      4'hF:    code = 7'h0E;
      default: code = 7'h7F;
    endcase
    return code;
  endfunction

  logic [SW-1:0]           slot_cnt_r;
  logic [IW-1:0]           idx_r;
  logic [BW-1:0]           blink_cnt_r;
  logic                    blink_phase_r;
  logic                    pending_r;
  logic [CW-1:0]           shadow_r;
  logic [CW-1:0]           active_r;

  logic                    slot_wrap_s;
  logic                    frame_end_s;
  logic                    frame_first_s;
  logic                    drive_s;
  logic [CW-1:0]           capture_s;
  logic [4*NUM_DIGITS-1:0] act_digits_s;
  logic [NUM_DIGITS-1:0]   act_dp_s;
  logic [NUM_DIGITS-1:0]   act_en_s;
  logic [NUM_DIGITS-1:0]   act_blink_s;
  logic                    act_lz_s;
  logic [NUM_DIGITS-1:0]   suppress_s;
  logic [NUM_DIGITS-1:0]   blanked_s;
  logic [NUM_DIGITS-1:0]   an_drive_s;
  logic [3:0]              cur_digit_s;
  logic                    cur_dp_s;
  logic                    cur_shown_s;

  assign slot_wrap_s   = (slot_cnt_r == SW'(SLOT_CYCLES - 1));
  assign frame_end_s   = slot_wrap_s && (idx_r == IW'(NUM_DIGITS - 1));
  assign frame_first_s = (slot_cnt_r == SW'(0)) && (idx_r == IW'(0));
  assign drive_s       = (slot_cnt_r >= SW'(BLANK_CYCLES));

  assign capture_s    = {lz_suppress, blink_in, enable_in, dp_in, digits_in};
  assign act_digits_s = active_r[4*NUM_DIGITS-1:0];
  assign act_dp_s     = active_r[5*NUM_DIGITS-1:4*NUM_DIGITS];
  assign act_en_s     = active_r[6*NUM_DIGITS-1:5*NUM_DIGITS];
  assign act_blink_s  = active_r[7*NUM_DIGITS-1:6*NUM_DIGITS];
  assign act_lz_s     = active_r[7*NUM_DIGITS];

  assign blanked_s = ~act_en_s | (act_blink_s & {NUM_DIGITS{blink_phase_r}}) | suppress_s;

  // Slot counter and digit index; idx advances when a slot completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt_r <= SW'(0);
      idx_r      <= IW'(0);
    end else if (slot_wrap_s) begin
      slot_cnt_r <= SW'(0);
      if (idx_r == IW'(NUM_DIGITS - 1)) begin
        idx_r <= IW'(0);
      end else begin
        idx_r <= idx_r + IW'(1);
      end
    end else begin
      slot_cnt_r <= slot_cnt_r + SW'(1);
    end
  end

  // Blink half-period counted in whole frames so the phase only flips between frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_r   <= BW'(0);
      blink_phase_r <= 1'b0;
    end else if (frame_end_s) begin
      if (blink_cnt_r == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_r   <= BW'(0);
        blink_phase_r <= ~blink_phase_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BW'(1);
      end
    end
  end

  // Double buffer: loads land in shadow; active only changes at the frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_r  <= {CW{1'b0}};
      active_r  <= {CW{1'b0}};
      pending_r <= 1'b0;
    end else begin
      if (load) begin
        shadow_r <= capture_s;
      end
      if (frame_end_s && load) begin
        active_r  <= capture_s;
        pending_r <= 1'b0;
      end else if (frame_end_s && pending_r) begin
        active_r  <= shadow_r;
        pending_r <= 1'b0;
      end else if (load) begin
        pending_r <= 1'b1;
      end
    end
  end

  // Leading-zero mask: zeros above the most significant non-zero digit; digit 0 always kept.
  always_comb begin
    logic seen;
    seen       = 1'b0;
    suppress_s = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (act_digits_s[4*i +: 4] != 4'h0) begin
        seen = 1'b1;
      end else begin
        seen = seen;
      end
      if (act_lz_s && !seen) begin
        suppress_s[i] = 1'b1;
      end else begin
        suppress_s[i] = 1'b0;
      end
    end
  end

  // Select the current digit's value, dp and visibility, and its one-hot anode pattern.
  always_comb begin
    cur_digit_s = 4'h0;
    cur_dp_s    = 1'b0;
    cur_shown_s = 1'b0;
    an_drive_s  = {NUM_DIGITS{1'b1}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_r == IW'(i)) begin
        cur_digit_s   = act_digits_s[4*i +: 4];
        cur_dp_s      = act_dp_s[i];
        cur_shown_s   = ~blanked_s[i];
        an_drive_s[i] = 1'b0;
      end else begin
        an_drive_s[i] = 1'b1;
      end
    end
  end

  // Registered pin drivers; the dead time and blanked digits keep every pin dark.
  always_ff @(posedge clk) begin
    if (reset) begin
      an          <= {NUM_DIGITS{1'b1}};
      seg         <= 7'h7F;
      dp          <= 1'b1;
      bcd_out     <= 4'h0;
      digit_sel   <= IW'(0);
      frame_start <= 1'b0;
    end else begin
      bcd_out     <= cur_digit_s;
      digit_sel   <= idx_r;
      frame_start <= frame_first_s;
      if (drive_s && cur_shown_s) begin
        an  <= an_drive_s;
        seg <= hex_to_seg(cur_digit_s);
        dp  <= ~cur_dp_s;
      end else begin
        an  <= {NUM_DIGITS{1'b1}};
        seg <= 7'h7F;
        dp  <= 1'b1;
      end
    end
  end

endmodule
